// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : load/store sequencer with big-endian lane steering,
//                   ready-based memory handshake and access timeout.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_bitext,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] rd_data_raw,
  output logic [1:0]  rd_offset,
  output logic [1:0]  rd_size,
  output logic        rd_bitext,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  state_t           state, state_nxt;
  logic             legal;
  logic             accept;
  logic             timeout;
  logic [3:0]       lane_we;
  logic [31:0]      lane_data;
  logic [CNT_W-1:0] cnt;
  logic             pend_write;
  logic [1:0]       pend_offset;
  logic [1:0]       pend_size;
  logic             pend_bitext;

  always_comb begin
    legal     = 1'b0;
    lane_we   = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        legal   = (req_addr[1:0] == 2'b00);
        lane_we = 4'b1111;
      end
      2'b01: begin
        legal     = ~req_addr[0];
        lane_data = {2{req_wdata[15:0]}};
        lane_we   = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        legal     = 1'b1;
        lane_data = {4{req_wdata[7:0]}};
        lane_we   = 4'b1000 >> req_addr[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && req_valid && legal;
  assign timeout = (TIMEOUT_CYCLES != 0) && !mem_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACCESS;
          busy      = 1'b1;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        // A ready arriving on the final allowed cycle still completes the access.
        if (mem_ready)    state_nxt = RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 4'b0000;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      rd_data_raw <= 32'h0;
      rd_offset   <= 2'b00;
      rd_size     <= 2'b00;
      rd_bitext   <= 1'b0;
      done        <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      cnt         <= '0;
      pend_write  <= 1'b0;
      pend_offset <= 2'b00;
      pend_size   <= 2'b00;
      pend_bitext <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_en      <= 1'b1;
            mem_addr    <= {req_addr[31:2], 2'b00};
            mem_wdata   <= lane_data;
            mem_we      <= req_write ? lane_we : 4'b0000;
            cnt         <= '0;
            pend_write  <= req_write;
            pend_offset <= req_addr[1:0];
            pend_size   <= req_size;
            pend_bitext <= req_bitext;
          end else if (req_valid) begin
            addr_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            mem_we <= 4'b0000;
            done   <= 1'b1;
            // Decoder-side info only moves on a completed load.
            if (!pend_write) begin
              rd_data_raw <= mem_rdata;
              rd_offset   <= pend_offset;
              rd_size     <= pend_size;
              rd_bitext   <= pend_bitext;
            end
          end else if (timeout) begin
            mem_en  <= 1'b0;
            mem_we  <= 4'b0000;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Directed bench: default-timeout instance (d_*) plus a TIMEOUT_CYCLES=4 instance (t_*).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_bitext, mem_ready;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [1:0]  req_size;

  logic        d_busy, d_mem_en, d_rd_bitext, d_done, d_addr_err, d_bus_err;
  logic [3:0]  d_mem_we;
  logic [31:0] d_mem_addr, d_mem_wdata, d_rd_data_raw;
  logic [1:0]  d_rd_offset, d_rd_size;

  logic        t_busy, t_mem_en, t_rd_bitext, t_done, t_addr_err, t_bus_err;
  logic [3:0]  t_mem_we;
  logic [31:0] t_mem_addr, t_mem_wdata, t_rd_data_raw;
  logic [1:0]  t_rd_offset, t_rd_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit u_dflt (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_bitext(req_bitext),
    .req_wdata(req_wdata), .busy(d_busy), .mem_en(d_mem_en), .mem_we(d_mem_we),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rd_data_raw(d_rd_data_raw), .rd_offset(d_rd_offset),
    .rd_size(d_rd_size), .rd_bitext(d_rd_bitext), .done(d_done),
    .addr_err(d_addr_err), .bus_err(d_bus_err)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_to4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_bitext(req_bitext),
    .req_wdata(req_wdata), .busy(t_busy), .mem_en(t_mem_en), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rd_data_raw(t_rd_data_raw), .rd_offset(t_rd_offset),
    .rd_size(t_rd_size), .rd_bitext(t_rd_bitext), .done(t_done),
    .addr_err(t_addr_err), .bus_err(t_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic bx, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_size   = size;
    req_bitext = bx;
    req_wdata  = wd;
  endtask

  // Store with a single-cycle ready; checks lane steering and completion.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_we, input logic [31:0] exp_data,
                          input logic [31:0] keep_raw);
    set_req(1'b1, addr, size, 1'b0, wd);
    #1 chk({tag, "_busy_accept"}, d_busy, 1);
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_mem_en"}, d_mem_en, 1);
    chk({tag, "_mem_addr"}, d_mem_addr, exp_addr);
    chk({tag, "_mem_we"}, d_mem_we, exp_we);
    chk({tag, "_mem_wdata"}, d_mem_wdata, exp_data);
    tick();
    mem_ready = 1'b0;
    #1;
    chk({tag, "_done"}, d_done, 1);
    chk({tag, "_mem_en_drop"}, d_mem_en, 0);
    chk({tag, "_raw_kept"}, d_rd_data_raw, keep_raw);
    tick();
  endtask

  // Load with a single-cycle ready; checks captured word and decoder info.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic bx, input logic [31:0] rdata, input logic [31:0] exp_addr);
    set_req(1'b0, addr, size, bx, 32'h0);
    #1 chk({tag, "_busy_accept"}, d_busy, 1);
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = rdata;
    #1;
    chk({tag, "_mem_en"}, d_mem_en, 1);
    chk({tag, "_mem_addr"}, d_mem_addr, exp_addr);
    chk({tag, "_mem_we"}, d_mem_we, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #1;
    chk({tag, "_done"}, d_done, 1);
    chk({tag, "_busy_resp"}, d_busy, 0);
    chk({tag, "_rd_data_raw"}, d_rd_data_raw, rdata);
    chk({tag, "_rd_offset"}, d_rd_offset, addr[1:0]);
    chk({tag, "_rd_size"}, d_rd_size, size);
    chk({tag, "_rd_bitext"}, d_rd_bitext, bx);
    tick();
    chk({tag, "_done_single"}, d_done, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_bitext = 1'b0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_mem_en", d_mem_en, 0);
    chk("rst_mem_addr", d_mem_addr, 0);
    chk("rst_rd_data_raw", d_rd_data_raw, 0);
    chk("rst_done", d_done, 0);
    chk("rst_busy", d_busy, 0);
    rst = 1'b0;
    tick();

    do_load("wload", 32'h0000_0100, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100);
    do_store("bst3", 32'h0000_0203, 2'b10, 32'h0000_00A5, 32'h0000_0200, 4'b0001,
             32'hA5A5_A5A5, 32'hDEAD_BEEF);
    do_store("bst0", 32'h0000_0200, 2'b10, 32'h0000_00A5, 32'h0000_0200, 4'b1000,
             32'hA5A5_A5A5, 32'hDEAD_BEEF);
    do_store("hst2", 32'h0000_0302, 2'b01, 32'h0000_1234, 32'h0000_0300, 4'b0011,
             32'h1234_1234, 32'hDEAD_BEEF);
    do_store("wst", 32'h0000_0310, 2'b00, 32'h8765_4321, 32'h0000_0310, 4'b1111,
             32'h8765_4321, 32'hDEAD_BEEF);
    do_load("bload3", 32'h0000_0507, 2'b10, 1'b0, 32'h1122_3344, 32'h0000_0504);

    // Misaligned half load
    set_req(1'b0, 32'h0000_0301, 2'b01, 1'b0, 32'h0);
    #1 chk("mis_busy", d_busy, 0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("mis_addr_err", d_addr_err, 1);
    chk("mis_mem_en", d_mem_en, 0);
    chk("mis_done", d_done, 0);
    tick();
    chk("mis_addr_err_single", d_addr_err, 0);

    // Reserved size
    set_req(1'b0, 32'h0000_0400, 2'b11, 1'b0, 32'h0);
    #1 chk("rsv_busy", d_busy, 0);
    tick();
    req_valid = 1'b0;
    #1 chk("rsv_addr_err", d_addr_err, 1);
    tick();

    // Five wait states; the 4-cycle instance times out meanwhile
    set_req(1'b0, 32'h0000_0400, 2'b00, 1'b1, 32'h0);
    #1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("ws_mem_en", d_mem_en, 1);
      chk("ws_mem_addr", d_mem_addr, 32'h0000_0400);
      chk("ws_busy", d_busy, 1);
      if (i == 4) chk("ws_to4_bus_err", t_bus_err, 1);
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1 chk("ws_mem_en_ready", d_mem_en, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ws_done", d_done, 1);
    chk("ws_rd_data_raw", d_rd_data_raw, 32'hCAFE_F00D);
    chk("ws_rd_bitext", d_rd_bitext, 1);
    tick();

    // Timeout on the TIMEOUT_CYCLES=4 instance
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(1'b0, 32'h0000_0602, 2'b01, 1'b1, 32'h0);
    #1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_mem_en", t_mem_en, 1);
      chk("to_bus_err_early", t_bus_err, 0);
      tick();
    end
    chk("to_mem_en_off", t_mem_en, 0);
    chk("to_bus_err", t_bus_err, 1);
    chk("to_done", t_done, 0);
    chk("to_busy", t_busy, 0);
    chk("to_rd_offset_kept", t_rd_offset, 0);
    chk("to_rd_bitext_kept", t_rd_bitext, 0);
    chk("to_dflt_still_waiting", d_mem_en, 1);
    tick();
    chk("to_bus_err_single", t_bus_err, 0);
    chk("to_done_after", t_done, 0);

    // Reset in cycle 2 of a wait
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(1'b1, 32'h0000_0800, 2'b00, 1'b0, 32'h5555_AAAA);
    #1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_mem_en_before", d_mem_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_mem_en", d_mem_en, 0);
    chk("mr_busy", d_busy, 0);
    chk("mr_mem_addr", d_mem_addr, 0);
    chk("mr_mem_we", d_mem_we, 0);
    chk("mr_mem_wdata", d_mem_wdata, 0);
    chk("mr_done", d_done, 0);
    tick();
    do_load("fresh", 32'h0000_0700, 2'b00, 1'b0, 32'h0BAD_F00D, 32'h0000_0700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
